// File: rtl/rect_ctl_pkg.sv
// Shared types and screen constants for the rectangle motion controller.
package rect_ctl_pkg;

    localparam int unsigned H_RES  = 800;
    localparam int unsigned V_RES  = 600;
    localparam int unsigned RECT_H = 64;
    localparam int unsigned RECT_W = 48;
    localparam int unsigned POS_W  = 12;
    localparam int unsigned VEL_W  = 12;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        RUN    = 2'd1,
        REST   = 2'd2
    } state_t;

endpackage

// File: rtl/edge_rise_det.sv
// Single-cycle rising-edge detector.
//   clk   : clock
//   rst   : asynchronous active-low reset (clears history)
//   d     : level input, synchronous to clk
//   pulse : d & ~d_prev, combinational, one clk wide
module edge_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // History register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/rect_bounce_ctl.sv
// Frame-synchronous rectangle motion controller: follows the mouse, drops
// under gravity after a left click, bounces with damping, rests on the floor.
//   clk        : pixel/system clock
//   rst        : asynchronous active-low reset
//   vblnk      : vertical blank level (updates happen on its rising edge)
//   mouse_left : left button level
//   mouse_xpos : pointer x
//   mouse_ypos : pointer y
//   xpos, ypos : registered rectangle origin
//   busy       : registered, high while falling/bouncing
module rect_bounce_ctl
    import rect_ctl_pkg::*;
#(
    parameter int unsigned FLOOR_Y    = V_RES - RECT_H,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned DAMP_SHIFT = 1,
    parameter int unsigned MIN_V      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic             mouse_left,
    input  logic [POS_W-1:0] mouse_xpos,
    input  logic [POS_W-1:0] mouse_ypos,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             busy
);

    localparam int unsigned Y_W = POS_W + 1;

    localparam logic [POS_W-1:0]      FLOOR_U = POS_W'(FLOOR_Y);
    localparam logic signed [Y_W-1:0] FLOOR_S = Y_W'(FLOOR_Y);
    localparam logic signed [Y_W-1:0] GRAV_S  = Y_W'(GRAVITY);
    localparam logic signed [Y_W-1:0] MIN_S   = Y_W'(MIN_V);

    logic [1:0] rst_sync;
    logic       rst_s;
    logic       tick;
    logic       click;

    state_t                  state, state_nxt;
    logic [POS_W-1:0]        xpos_nxt, ypos_nxt;
    logic signed [VEL_W-1:0] vy, vy_nxt;
    logic                    busy_nxt;

    logic signed [Y_W-1:0]   v1, y1, r;
    logic [POS_W-1:0]        mouse_y_clamped;

    // Reset synchroniser: asserts immediately, releases two clocks after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_s = rst_sync[1];

    edge_rise_det u_vblnk_det (
        .clk   (clk),
        .rst   (rst_s),
        .d     (vblnk),
        .pulse (tick)
    );

    edge_rise_det u_left_det (
        .clk   (clk),
        .rst   (rst_s),
        .d     (mouse_left),
        .pulse (click)
    );

    // Physics step, computed in 13-bit signed so negative y and overshoot are visible
    always_comb begin
        v1 = Y_W'(vy) + GRAV_S;
        y1 = $signed({1'b0, ypos}) + v1;
        r  = v1 - (v1 >>> DAMP_SHIFT);
        mouse_y_clamped = (mouse_ypos > FLOOR_U) ? FLOOR_U : mouse_ypos;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state <= FOLLOW;
            xpos  <= '0;
            ypos  <= '0;
            vy    <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            xpos  <= xpos_nxt;
            ypos  <= ypos_nxt;
            vy    <= vy_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        xpos_nxt  = xpos;
        ypos_nxt  = ypos;
        vy_nxt    = vy;

        unique case (state)
            FOLLOW: begin
                // A coincident tick still samples the pointer before the drop starts
                if (tick) begin
                    xpos_nxt = mouse_xpos;
                    ypos_nxt = mouse_y_clamped;
                end
                if (click) begin
                    state_nxt = RUN;
                    vy_nxt    = '0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (y1 < FLOOR_S) begin
                        ypos_nxt = (y1 < 0) ? '0 : POS_W'(y1);
                        vy_nxt   = VEL_W'(v1);
                    end else begin
                        ypos_nxt = FLOOR_U;
                        if (r < MIN_S) begin
                            state_nxt = REST;
                            vy_nxt    = '0;
                        end else begin
                            vy_nxt = VEL_W'(-r);
                        end
                    end
                end
            end
            REST: begin
                if (click) begin
                    state_nxt = FOLLOW;
                end
            end
            default: begin
                state_nxt = FOLLOW;
                vy_nxt    = '0;
            end
        endcase

        busy_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_rect_bounce_ctl.sv
// Scoreboard bench for rect_bounce_ctl: stimulus pushes expected outputs,
// monitors pop and compare after each vblnk rise or on explicit request.
module tb_rect_bounce_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        b;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic vb_prev  = 1'b0;
    logic mon_tick = 1'b0;
    event req_ev;

    int drop_y[18] = '{501, 503, 506, 510, 515, 521, 528, 536,
                       533, 531, 530, 530, 531, 533, 536,
                       535, 535, 536};

    rect_bounce_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .mouse_left (mouse_left),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic do_check();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_underflow: output at t=%0t with no expectation", $time);
        end else begin
            e = sb_q.pop_front();
            if (xpos !== e.x || ypos !== e.y || busy !== e.b) begin
                n_errors++;
                $display("FAIL %s: got x=%0d y=%0d busy=%0b, expected x=%0d y=%0d busy=%0b",
                         e.tag, xpos, ypos, busy, e.x, e.y, e.b);
            end
        end
    endtask

    // Monitor: a vblnk rise seen at a posedge means new outputs by the next negedge
    always @(posedge clk) begin
        mon_tick <= vblnk & ~vb_prev;
        vb_prev  <= vblnk;
    end

    always @(negedge clk) begin
        if (mon_tick) do_check();
    end

    always begin
        @(req_ev);
        do_check();
    end

    task automatic expect_out(input int x, input int y, input logic b, input string tag);
        exp_t e;
        e.x = 12'(x);
        e.y = 12'(y);
        e.b = b;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input int x, input int y, input logic b, input string tag);
        expect_out(x, y, b, tag);
        -> req_ev;
        #1;
    endtask

    task automatic frame(input int x, input int y, input logic b, input string tag);
        @(posedge clk); #2;
        vblnk = 1'b1;
        expect_out(x, y, b, tag);
        @(posedge clk); #2;
        vblnk = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic click();
        @(posedge clk); #2;
        mouse_left = 1'b1;
        @(posedge clk); #2;
        mouse_left = 1'b0;
    endtask

    task automatic set_mouse(input int x, input int y);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
    endtask

    task automatic release_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        set_mouse(300, 200);
        repeat (3) @(posedge clk);
        #2;
        check_now(0, 0, 1'b0, "reset_init");
        release_reset();

        set_mouse(5, 6);
        frame(5, 6, 1'b0, "track_before_reset");

        // Mid-sim reset while following
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_now(0, 0, 1'b0, "reset_mid_follow");
        repeat (2) @(posedge clk);
        release_reset();

        set_mouse(300, 200);
        for (int i = 0; i < 3; i++) frame(300, 200, 1'b0, "track");

        // Clamp boundaries
        set_mouse(300, 700);
        frame(300, 536, 1'b0, "clamp_700");
        set_mouse(300, 537);
        frame(300, 536, 1'b0, "clamp_537");
        set_mouse(300, 536);
        frame(300, 536, 1'b0, "clamp_536");
        set_mouse(300, 535);
        frame(300, 535, 1'b0, "clamp_535");

        // Full drop sequence, mouse movement ignored while running
        set_mouse(120, 500);
        frame(120, 500, 1'b0, "drop_start");
        click();
        check_now(120, 500, 1'b1, "click_to_run");
        set_mouse(999, 5);
        for (int i = 0; i < 18; i++)
            frame(120, drop_y[i], (i == 17) ? 1'b0 : 1'b1, "drop");

        // Back to FOLLOW, then a drop with clicks during RUN
        click();
        check_now(120, 536, 1'b0, "rest_click");
        set_mouse(120, 500);
        frame(120, 500, 1'b0, "drop2_start");
        click();
        check_now(120, 500, 1'b1, "click_to_run2");
        set_mouse(10, 10);
        for (int i = 0; i < 18; i++) begin
            frame(120, drop_y[i], (i == 17) ? 1'b0 : 1'b1, "drop_clicks");
            if (i >= 2 && i <= 4) click();
        end

        // REST holds, held click returns to FOLLOW exactly once
        set_mouse(400, 100);
        frame(120, 536, 1'b0, "rest_hold");
        @(posedge clk); #2;
        mouse_left = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_now(120, 536, 1'b0, "rest_click_held");
        frame(400, 100, 1'b0, "rest_to_follow");
        set_mouse(410, 110);
        frame(410, 110, 1'b0, "held_no_retrigger");
        @(posedge clk); #2;
        mouse_left = 1'b0;
        repeat (2) @(posedge clk);

        // Simultaneous tick and click in FOLLOW
        set_mouse(50, 300);
        @(posedge clk); #2;
        vblnk = 1'b1;
        mouse_left = 1'b1;
        expect_out(50, 300, 1'b1, "tick_click_follow");
        @(posedge clk); #2;
        vblnk = 1'b0;
        mouse_left = 1'b0;
        repeat (3) @(posedge clk);
        frame(50, 301, 1'b1, "first_gravity");
        frame(50, 303, 1'b1, "second_gravity");

        // Async reset mid-RUN
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_now(0, 0, 1'b0, "reset_mid_run");
        repeat (2) @(posedge clk);
        release_reset();
        set_mouse(7, 8);
        frame(7, 8, 1'b0, "after_reset_follow");
        click();
        check_now(7, 8, 1'b1, "after_reset_click");
        frame(7, 9, 1'b1, "vy_cleared");

        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_now(0, 0, 1'b0, "reset_mid_run2");
        release_reset();

        // Below-floor pointer: first tick in RUN is straight to impact and rest
        set_mouse(30, 900);
        frame(30, 536, 1'b0, "floor_follow");
        click();
        check_now(30, 536, 1'b1, "floor_click");
        frame(30, 536, 1'b0, "immediate_impact_rest");

        // Simultaneous tick and click in REST
        set_mouse(60, 70);
        @(posedge clk); #2;
        vblnk = 1'b1;
        mouse_left = 1'b1;
        expect_out(30, 536, 1'b0, "tick_click_rest");
        @(posedge clk); #2;
        vblnk = 1'b0;
        mouse_left = 1'b0;
        repeat (3) @(posedge clk);
        frame(60, 70, 1'b0, "rest_to_follow_tick");

        repeat (5) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
